// File: rtl/sdf_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : sdf_delay_line
//  Purpose  : Run-time selectable complex feedback delay (L = DEPTH_MAX>>len_sel)
//             for single-path delay-feedback FFT stages, built on a circular
//             buffer. Also exports the stage phase for butterfly/bypass muxes.
//  Option   : SDF_DELAY_FLUSH_EN - after a burst ends the block self-advances
//             L cycles with zero input so every stored sample is emitted.
//  Revision : 1.0 - initial release
// ============================================================================
module sdf_delay_line #(
   parameter int DATA_W    = 24,
   parameter int DEPTH_MAX = 512
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [3:0]               len_sel,
   input  logic signed [DATA_W-1:0] din_r,
   input  logic signed [DATA_W-1:0] din_i,
   output logic signed [DATA_W-1:0] dout_r,
   output logic signed [DATA_W-1:0] dout_i,
   output logic                     out_valid,
   output logic                     phase,
   output logic                     busy
);

   localparam int           AW      = $clog2(DEPTH_MAX);
   localparam logic [AW:0]  DEPTH_L = (AW+1)'(DEPTH_MAX);
   localparam logic [4:0]   AW_L    = 5'(AW);
   localparam logic [AW:0]  ONE_L   = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t                state, state_nxt;
   logic [3:0]            len_q;
   logic [AW-1:0]         wr_ptr;
   logic [AW:0]           adv_cnt;
   logic [AW:0]           fill_cnt;

   logic [2*DATA_W-1:0]   mem [DEPTH_MAX];

   logic                  start;
   logic                  advance;
   logic                  flush_adv;
   logic                  flush_last;
   logic [3:0]            len_src;
   logic [AW:0]           dly_len;
   logic [AW+1:0]         two_l_m1;
   logic [AW:0]           fill_eff;
   logic [AW:0]           adv_eff;
   logic [AW-1:0]         rd_addr;
   logic [2*DATA_W-1:0]   rd_word;
   logic [2*DATA_W-1:0]   wr_data;

   // The IDLE->RUN cycle is itself an advance, so it must already see the new
   // length and freshly cleared counters.
   assign start = (state == IDLE) && in_valid;

`ifdef SDF_DELAY_FLUSH_EN
   logic [AW:0] flush_cnt;
   assign flush_adv  = (state == FLUSH) && !in_valid;
   assign flush_last = flush_adv && (flush_cnt == dly_len - ONE_L);
`else
   assign flush_adv  = 1'b0;
   assign flush_last = 1'b0;
`endif

   assign advance = in_valid | flush_adv;
   assign busy    = (state != IDLE);

   // Derive the active delay, effective counters and buffer addresses.
   always_comb begin
      len_src = start ? len_sel : len_q;
      if ({1'b0, len_src} > AW_L) begin
         dly_len = ONE_L;
      end else begin
         dly_len = DEPTH_L >> len_src;
      end
      two_l_m1 = {dly_len, 1'b0} - (AW+2)'(1);
      fill_eff = start ? '0 : fill_cnt;
      adv_eff  = start ? '0 : adv_cnt;
      // With L = DEPTH_MAX the low AW bits of L are zero, so the read hits the
      // slot about to be overwritten and returns its old content.
      rd_addr  = wr_ptr - dly_len[AW-1:0];
      rd_word  = mem[rd_addr];
      wr_data  = flush_adv ? '0 : {din_r, din_i};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN: begin
            if (!in_valid) begin
`ifdef SDF_DELAY_FLUSH_EN
               state_nxt = FLUSH;
`else
               state_nxt = IDLE;
`endif
            end
         end
         FLUSH: begin
            if (in_valid)        state_nxt = RUN;
            else if (flush_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sample storage; deliberately not reset, stale content is masked by fill_cnt.
   always_ff @(posedge clk) begin
      if (advance) mem[wr_ptr] <= wr_data;
   end

   // Pointer, counters and registered outputs; all hold on non-advance cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         wr_ptr    <= '0;
         adv_cnt   <= '0;
         fill_cnt  <= '0;
         dout_r    <= '0;
         dout_i    <= '0;
         out_valid <= 1'b0;
         phase     <= 1'b0;
      end else begin
         if (start) len_q <= len_sel;
         if (advance) begin
            wr_ptr    <= wr_ptr + 1'b1;
            out_valid <= (fill_eff >= dly_len);
            phase     <= (adv_eff >= dly_len);
            if (fill_eff < dly_len) begin
               dout_r   <= '0;
               dout_i   <= '0;
               fill_cnt <= fill_eff + ONE_L;
            end else begin
               dout_r   <= rd_word[2*DATA_W-1:DATA_W];
               dout_i   <= rd_word[DATA_W-1:0];
               fill_cnt <= fill_eff;
            end
            if ({1'b0, adv_eff} == two_l_m1) adv_cnt <= '0;
            else                             adv_cnt <= adv_eff + ONE_L;
         end
      end
   end

`ifdef SDF_DELAY_FLUSH_EN
   // Flush advance counter; cleared by any input-driven advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt <= '0;
      end else if (advance) begin
         if (!flush_adv || flush_last) flush_cnt <= '0;
         else                          flush_cnt <= flush_cnt + ONE_L;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdf_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdf_delay_line
//  Purpose  : Self-checking bench for sdf_delay_line. A behavioural model keeps
//             the sample history of the current burst and pushes the expected
//             output of every cycle into a scoreboard queue.
//  Option   : honours SDF_DELAY_FLUSH_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdf_delay_line;

   localparam int DATA_W    = 24;
   localparam int DEPTH_MAX = 512;
   localparam int AW        = 9;
`ifdef SDF_DELAY_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [3:0]        len_sel;
   logic [DATA_W-1:0] din_r, din_i;
   logic [DATA_W-1:0] dout_r, dout_i;
   logic              out_valid, phase, busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit                v;
      logic [3:0]        ls;
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] i;
   } stim_t;

   typedef struct {
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] i;
      logic              ov;
      logic              ph;
      logic              bz;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              last;
   logic [2*DATA_W-1:0] hist[$];
   int                bm_st, bm_len, bm_j, bm_fc;

   sdf_delay_line #(.DATA_W(DATA_W), .DEPTH_MAX(DEPTH_MAX)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .len_sel(len_sel),
      .din_r(din_r), .din_i(din_i), .dout_r(dout_r), .dout_i(dout_i),
      .out_valid(out_valid), .phase(phase), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int lval(input logic [3:0] s);
      return (int'(s) > AW) ? 1 : (DEPTH_MAX >> s);
   endfunction

   function automatic stim_t mk(input bit v, input logic [3:0] ls,
                                input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] i);
      stim_t s;
      s.v = v; s.ls = ls; s.r = r; s.i = i;
      return s;
   endfunction

   task automatic model_reset();
      bm_st = 0; bm_len = 1; bm_j = 0; bm_fc = 0;
      hist.delete();
      last.r = '0; last.i = '0; last.ov = 1'b0; last.ph = 1'b0; last.bz = 1'b0;
   endtask

   // Drive one cycle and push what the outputs must show after its edge.
   task automatic step(input stim_t s);
      bit adv, fadv;
      logic [2*DATA_W-1:0] smp;
      in_valid = s.v; len_sel = s.ls; din_r = s.r; din_i = s.i;
      if (bm_st == 0 && s.v) begin
         bm_len = lval(s.ls); bm_j = 0; hist.delete();
      end
      adv = s.v || (bm_st == 2);
      if (adv) begin
         fadv = (bm_st == 2) && !s.v;
         smp  = fadv ? '0 : {s.r, s.i};
         last.ov = (bm_j >= bm_len);
         {last.r, last.i} = last.ov ? hist[bm_j - bm_len] : '0;
         last.ph = (bm_j % (2 * bm_len)) >= bm_len;
         hist.push_back(smp);
         bm_j++;
      end
      case (bm_st)
         0: if (s.v) bm_st = 1;
         1: if (!s.v) begin bm_st = FLUSH_EN ? 2 : 0; bm_fc = 0; end
         2: begin
            if (s.v) begin bm_st = 1; bm_fc = 0; end
            else if (bm_fc == bm_len - 1) begin bm_st = 0; bm_fc = 0; end
            else bm_fc++;
         end
         default: bm_st = 0;
      endcase
      last.bz = (bm_st != 0);
      exp_q.push_back(last);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; len_sel = '0; din_r = '0; din_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({dout_r, dout_i, out_valid, phase, busy} !== '0) begin
         bad++;
         $display("FAIL reset_state got r=%h i=%h v=%b p=%b b=%b exp all zero",
                  dout_r, dout_i, out_valid, phase, busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_len();
      stim_t q[$];
      exp_t  e;
      for (int n = 0; n < 1024; n++) q.push_back(mk(1'b1, 4'd0, DATA_W'(n), DATA_W'(-n)));
      for (int n = 0; n < 520; n++)  q.push_back(mk(1'b0, 4'd0, '0, '0));
      foreach (q[k]) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL full_len cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
   endtask

   task automatic test_short_len();
      stim_t q[$];
      exp_t  e;
      for (int n = 5; n <= 7; n++)  q.push_back(mk(1'b1, 4'd9, DATA_W'(n), DATA_W'(-n)));
      for (int n = 0; n < 4; n++)   q.push_back(mk(1'b0, 4'd9, '0, '0));
      // len_sel beyond the pointer width clamps to a one-sample delay
      for (int n = 0; n < 6; n++)   q.push_back(mk(1'b1, 4'd13, DATA_W'(100 + n), DATA_W'(n)));
      for (int n = 0; n < 4; n++)   q.push_back(mk(1'b0, 4'd13, '0, '0));
      foreach (q[k]) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL short_len cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
   endtask

   task automatic test_toggle();
      stim_t q[$];
      exp_t  e;
      for (int n = 0; n < 256; n++) begin
         q.push_back(mk(1'b1, 4'd2, DATA_W'(n * 3 + 1), DATA_W'(~n)));
         q.push_back(mk(1'b0, 4'd2, DATA_W'($urandom), DATA_W'($urandom)));
      end
      for (int n = 0; n < 140; n++) q.push_back(mk(1'b0, 4'd2, '0, '0));
      foreach (q[k]) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL toggle cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
   endtask

   task automatic test_len_change();
      stim_t q[$];
      exp_t  e;
      for (int n = 0; n < 200; n++)
         q.push_back(mk(1'b1, (n < 60) ? 4'd2 : 4'd4, DATA_W'(n + 7), DATA_W'(n * 5)));
      for (int n = 0; n < 140; n++) q.push_back(mk(1'b0, 4'd4, '0, '0));
      for (int n = 0; n < 80; n++)  q.push_back(mk(1'b1, 4'd4, DATA_W'(n + 900), DATA_W'(-n)));
      for (int n = 0; n < 40; n++)  q.push_back(mk(1'b0, 4'd4, '0, '0));
      foreach (q[k]) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL len_change cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t q[$];
      exp_t  e;
      for (int n = 0; n < 600; n++) q.push_back(mk(1'b1, 4'd0, DATA_W'(n + 11), DATA_W'(n)));
      for (int k = 0; k < 300; k++) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL reset_mid_pre cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
      // asynchronous reset asserted between clock edges
      in_valid = 1'b1;
      rst = 1'b1;
      #1;
      total++;
      if ({dout_r, dout_i, out_valid, phase, busy} !== '0) begin
         bad++;
         $display("FAIL reset_mid_async got r=%h i=%h v=%b p=%b b=%b exp all zero",
                  dout_r, dout_i, out_valid, phase, busy);
      end
      #2;
      in_valid = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      q.delete();
      for (int n = 0; n < 520; n++) q.push_back(mk(1'b1, 4'd0, 24'hABCDEF, 24'h123456));
      for (int n = 0; n < 520; n++) q.push_back(mk(1'b0, 4'd0, '0, '0));
      foreach (q[k]) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL reset_mid_post cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
   endtask

   task automatic test_wrap();
      stim_t q[$];
      exp_t  e;
      for (int n = 0; n < 600; n++)
         q.push_back(mk(1'b1, 4'd0, DATA_W'(n), DATA_W'($urandom)));
      for (int n = 0; n < 530; n++) q.push_back(mk(1'b0, 4'd0, '0, '0));
      foreach (q[k]) begin
         step(q[k]);
         e = exp_q.pop_front();
         total++;
         if ({dout_r, dout_i, out_valid, phase, busy} !== {e.r, e.i, e.ov, e.ph, e.bz}) begin
            bad++;
            $display("FAIL wrap cyc=%0d got r=%h i=%h v=%b p=%b b=%b exp r=%h i=%h v=%b p=%b b=%b",
                     k, dout_r, dout_i, out_valid, phase, busy, e.r, e.i, e.ov, e.ph, e.bz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_len();
      test_short_len();
      test_toggle();
      test_len_change();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
